ufm_shadow_loader: RTL

UFM_SHADOW_LOADER -- requirements
Module: ufm_shadow_loader

---
 rtl/ufm_shadow_pkg.sv | 25 ++
 rtl/ufm_timeout_ctr.sv | 30 +++
 rtl/ufm_shadow_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ufm_shadow_pkg.sv
// Shared definitions for the UFM shadow loader: FSM states, default
// parameter values and the checksum width.
package ufm_shadow_pkg;

    localparam int unsigned CSUM_W         = 32;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_FLASH_AW   = 16;
    localparam int unsigned DEF_RAM_AW     = 9;
    localparam int unsigned DEF_DEPTH      = 512;
    localparam int unsigned DEF_BASE_ADDR  = 0;
    localparam int unsigned DEF_BURST_LEN  = 2;
    localparam int unsigned DEF_BURST_W    = 2;
    localparam int unsigned DEF_TIMEOUT    = 1023;
    localparam int unsigned DEF_AUTO_START = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/ufm_timeout_ctr.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count reaches TIMEOUT.
module ufm_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Asserted on the idle cycle whose edge brings the count to TIMEOUT.
    assign expired = enable && !clear && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ufm_shadow_loader.sv
// Copies DEPTH words from an Avalon-MM burst flash port into a shadow RAM,
// keeps a running checksum and releases the consumer core when complete.
module ufm_shadow_loader
    import ufm_shadow_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FLASH_AW   = DEF_FLASH_AW,
    parameter int unsigned RAM_AW     = DEF_RAM_AW,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned BASE_ADDR  = DEF_BASE_ADDR,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned BURST_W    = DEF_BURST_W,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned AUTO_START = DEF_AUTO_START
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [FLASH_AW-1:0]   avmm_addr,
    output logic                  avmm_read,
    output logic [BURST_W-1:0]    avmm_burstcount,
    input  logic                  avmm_waitrequest,
    input  logic [DATA_W-1:0]     avmm_readdata,
    input  logic                  avmm_readdatavalid,
    output logic [RAM_AW-1:0]     ram_wr_addr,
    output logic [DATA_W-1:0]     ram_wr_data,
    output logic [DATA_W/8-1:0]   ram_wr_be,
    output logic                  ram_wr_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CSUM_W-1:0]     checksum,
    output logic                  cpu_reset_n
);

    localparam int unsigned CNT_W = RAM_AW + 1;
    localparam int unsigned NSL   = (DATA_W + 31) / 32;
    localparam int unsigned PAD_W = NSL * 32;

    state_t              r_state;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [BURST_W-1:0]  r_beats_left;
    logic                r_auto;
    logic [CSUM_W-1:0]   r_checksum;
    logic                r_read;
    logic [FLASH_AW-1:0] r_addr;
    logic [BURST_W-1:0]  r_bc;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_cpu_rst_n;

    logic                w_beat;
    logic                w_expired;
    logic                w_to_clear;
    logic                w_to_enable;
    logic [PAD_W-1:0]    w_pad;
    logic [CSUM_W-1:0]   w_beat_sum;
    logic [CNT_W-1:0]    w_next_cnt;

    function automatic logic [BURST_W-1:0] burst_for(input logic [CNT_W-1:0] cnt);
        int unsigned rem;
        rem = DEPTH - 32'(cnt);
        return BURST_W'((rem < BURST_LEN) ? rem : BURST_LEN);
    endfunction

    function automatic logic [FLASH_AW-1:0] addr_for(input logic [CNT_W-1:0] cnt);
        return FLASH_AW'(BASE_ADDR + 32'(cnt));
    endfunction

    // Beats beyond the requested burst are dropped so no write passes DEPTH.
    assign w_beat      = (r_state == ST_DATA) && avmm_readdatavalid && (r_beats_left != '0);
    assign w_next_cnt  = r_word_cnt + 1'b1;
    assign w_pad       = PAD_W'(avmm_readdata);
    assign w_to_clear  = (r_state != ST_DATA) || w_beat;
    assign w_to_enable = (r_state == ST_DATA) && !w_beat;

    always_comb begin
        w_beat_sum = '0;
        for (int unsigned i = 0; i < NSL; i++) begin
            w_beat_sum = w_beat_sum + w_pad[i*32 +: 32];
        end
    end

    ufm_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_to_clear),
        .enable  (w_to_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_word_cnt   <= '0;
            r_beats_left <= '0;
            r_auto       <= (AUTO_START != 0);
            r_checksum   <= '0;
            r_read       <= 1'b0;
            r_addr       <= '0;
            r_bc         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start || ((r_state == ST_IDLE) && r_auto)) begin
                        r_state     <= ST_REQ;
                        r_word_cnt  <= '0;
                        r_checksum  <= '0;
                        r_auto      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
                        r_read      <= 1'b1;
                        r_addr      <= addr_for('0);
                        r_bc        <= burst_for('0);
                    end
                end
                ST_REQ: begin
                    if (!avmm_waitrequest) begin
                        r_state      <= ST_DATA;
                        r_read       <= 1'b0;
                        r_beats_left <= r_bc;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        r_word_cnt   <= w_next_cnt;
                        r_checksum   <= r_checksum + w_beat_sum;
                        r_beats_left <= r_beats_left - 1'b1;
                        if (r_beats_left == BURST_W'(1)) begin
                            if (32'(w_next_cnt) < DEPTH) begin
                                r_state <= ST_REQ;
                                r_read  <= 1'b1;
                                r_addr  <= addr_for(w_next_cnt);
                                r_bc    <= burst_for(w_next_cnt);
                            end else begin
                                r_state     <= ST_DONE;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_cpu_rst_n <= 1'b1;
                            end
                        end
                    end else if (w_expired) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign avmm_read       = r_read;
    assign avmm_addr       = r_addr;
    assign avmm_burstcount = r_bc;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign checksum        = r_checksum;
    assign cpu_reset_n     = r_cpu_rst_n;

    assign ram_wr_we   = w_beat;
    assign ram_wr_addr = w_beat ? r_word_cnt[RAM_AW-1:0] : '0;
    assign ram_wr_data = w_beat ? avmm_readdata : '0;
    assign ram_wr_be   = {(DATA_W/8){w_beat}};

endmodule
